core_input_dispatch: RTL and testbench
======================================

Name: core_input_dispatch

Overview:
Parametrised successor to the per-core input decoder in the md5engine input path. It accepts a word stream from realign and steers each N_WORDS-word block to one core's input buffer, decoding a packed thread number into per-core write enable, context and sequence. Compared with the earlier decoder it adds generic block length and thread fields, a block-level state machine, per-thread buffer-full backpressure, and sticky protocol-error reporting. The per-thread full flags come from the cores.

Parameters:
N_CORES, 4, number of cores; need not be a power of two
N_CTX, 2, contexts per core; power of two, at least 2
N_SEQ, 2, sequences per context; power of two, at least 2
N_WORDS, 16, 32-bit words per block; power of two, 2..64
BLK_OP_W, 2, width of blk_op
Derived: CORE_W=clog2(N_CORES) (min 1), CTX_W=clog2(N_CTX), SEQ_W=clog2(N_SEQ), TH_W=CORE_W+CTX_W+SEQ_W, ADDR_W=clog2(N_WORDS)

Ports:
CLK  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input word valid
in_ready  out  1  block accepts word this cycle (combinational)
in_data  in  32  input word
in_thread_num  in  TH_W  {core, ctx, seq}, seq in the LSBs
in_blk_op  in  BLK_OP_W  block operation; sampled on the first word only
thread_full  in  2^TH_W  per-thread input-buffer-full flags from the cores
core_wr_en  out  N_CORES  one-hot write enable
core_wr_addr  out  ADDR_W  word address within the block
core_din  out  32  write data
core_ctx_num  out  CTX_W  context of the current block
core_seq_num  out  SEQ_W  sequence of the current block
core_blk_op  out  BLK_OP_W  operation of the current block
set_input_ready  out  1  one-cycle pulse on the last word's write
ready_thread_num  out  TH_W  thread qualified by set_input_ready
err  out  1  sticky protocol error
err_code  out  2  1=thread change mid-block, 2=core index >= N_CORES; first error wins

Behaviour:
- Accept: in_valid & in_ready. States are IDLE (waiting for word 0) and BLOCK (words 1..N_WORDS-1).
- in_ready: in IDLE it is !thread_full[in_thread_num]. In BLOCK it is 1; fullness is checked only at block start.
- IDLE accept with a valid core: latch thread and blk_op, set cnt=1 and go to BLOCK. If N_WORDS words are already written, the block ends instead; since N_WORDS>=2 this cannot happen on word 0.
- BLOCK accept with in_thread_num equal to the latched thread: write the word and increment cnt. On the word with cnt==N_WORDS-1, set cnt=0 and go to IDLE.
- BLOCK accept with a different thread: drop the word, set err with code 1 (if err is still 0), stay in BLOCK, and leave cnt unchanged.
- IDLE accept with core index >= N_CORES: drop the word, set err with code 2 (if err is still 0), stay in IDLE.
- Write timing: 1-cycle registered latency. A word accepted at cycle t produces core_wr_en[core]=1 at t+1, with core_wr_addr = the word's index, core_din = in_data, and ctx/seq/blk_op of the block.
- core_wr_en is one-hot or zero, and nonzero only for written (not dropped) words.
- set_input_ready pulses in the same cycle as the write of the last word. ready_thread_num holds that thread and keeps its value until the next pulse.
- Back-to-back blocks: word 0 of the next block can be accepted the cycle after the last word is accepted, so there is no bubble. thread_full is sampled at that cycle.
- Gaps (in_valid=0) are allowed anywhere. State and cnt are held, and core_wr_en=0 on the following cycle.
- err and err_code stay set until rst.
- Reset values:
  - core_wr_en=0, set_input_ready=0, err=0, err_code=0, core_wr_addr=0, ready_thread_num=0.
  - core_din, ctx, seq and blk_op reset to 0.
  - state=IDLE, cnt=0.
- Reset mid-block abandons the partial block with no set_input_ready. No write occurs in the cycle after rst is asserted.
- rst asserted together with in_valid: reset wins and the word is not accepted.

Test Plan:
1. Default parameters, thread 0b1011 (core 2, ctx 1, seq 1), blk_op=2, 16 consecutive words 0..15 -> core_wr_en=4'b0100 for 16 cycles, addr 0..15, ctx=1, seq=1, blk_op=2; set_input_ready pulses with addr 15; ready_thread_num=0b1011.
2. Two back-to-back blocks to threads 0 and 13 -> 32 contiguous write cycles, pulses at cycles 16 and 32, and no bubble between blocks.
3. thread_full[5]=1 and word 0 for thread 5 presented -> in_ready=0 and no write. Release full after 3 cycles -> the block is accepted and addresses start at 0.
4. Mid-block, word 4 is presented with a different thread -> word dropped, err=1, err_code=1. Further words for the original thread write at addr 4..15.
5. N_CORES=3 with thread core field 3 -> dropped, err_code=2, state stays IDLE. rst asserted at word 7 of a block -> no pulse; the next block starts at addr 0.
6. N_WORDS=8, N_CTX=4 -> addresses wrap 0..7, the pulse comes on the 8th write, and the ctx field decodes 2 bits.

Source files
------------

// File: rtl/core_input_dispatch.sv
// core_input_dispatch: steers N_WORDS-word blocks from the realign stream into per-core
// input buffers, with a block-level FSM, per-thread backpressure and sticky error reporting.
module core_input_dispatch #(
    parameter int N_CORES  = 4,
    parameter int N_CTX    = 2,
    parameter int N_SEQ    = 2,
    parameter int N_WORDS  = 16,
    parameter int BLK_OP_W = 2,
    localparam int CORE_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1,
    localparam int CTX_W   = $clog2(N_CTX),
    localparam int SEQ_W   = $clog2(N_SEQ),
    localparam int TH_W    = CORE_W + CTX_W + SEQ_W,
    localparam int ADDR_W  = $clog2(N_WORDS)
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic [TH_W-1:0]       in_thread_num,
    input  logic [BLK_OP_W-1:0]   in_blk_op,
    input  logic [2**TH_W-1:0]    thread_full,
    output logic [N_CORES-1:0]    core_wr_en,
    output logic [ADDR_W-1:0]     core_wr_addr,
    output logic [31:0]           core_din,
    output logic [CTX_W-1:0]      core_ctx_num,
    output logic [SEQ_W-1:0]      core_seq_num,
    output logic [BLK_OP_W-1:0]   core_blk_op,
    output logic                  set_input_ready,
    output logic [TH_W-1:0]       ready_thread_num,
    output logic                  err,
    output logic [1:0]            err_code
);
    typedef enum logic {IDLE, BLOCK} state_t;
    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [TH_W-1:0]     cur_thread;
    logic [BLK_OP_W-1:0] cur_op;
    logic [CORE_W-1:0]   in_core;
    logic                core_ok, accept, same_thread, last, wr;
    assign in_core     = in_thread_num[SEQ_W+CTX_W +: CORE_W];
    assign core_ok     = 32'(in_core) < 32'(N_CORES);
    assign same_thread = in_thread_num == cur_thread;
    assign in_ready    = (state == IDLE) ? !thread_full[in_thread_num] : 1'b1;
    assign accept      = in_valid && in_ready;
    assign last        = cnt == ADDR_W'(N_WORDS - 1);
    // A word is written only if it opens a block for a real core or continues the latched thread
    assign wr          = accept && ((state == IDLE) ? core_ok : same_thread);
    always_ff @(posedge CLK) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            cur_thread       <= '0;
            cur_op           <= '0;
            core_wr_en       <= '0;
            core_wr_addr     <= '0;
            core_din         <= '0;
            core_ctx_num     <= '0;
            core_seq_num     <= '0;
            core_blk_op      <= '0;
            set_input_ready  <= 1'b0;
            ready_thread_num <= '0;
            err              <= 1'b0;
            err_code         <= 2'd0;
        end else begin
            core_wr_en      <= '0;
            set_input_ready <= 1'b0;
            if (wr) begin
                core_wr_en   <= N_CORES'(1) << in_core;
                core_wr_addr <= cnt;
                core_din     <= in_data;
                core_ctx_num <= in_thread_num[SEQ_W +: CTX_W];
                core_seq_num <= in_thread_num[SEQ_W-1:0];
                core_blk_op  <= (state == IDLE) ? in_blk_op : cur_op;
            end
            if (wr && state == IDLE) begin
                cur_thread <= in_thread_num;
                cur_op     <= in_blk_op;
                cnt        <= ADDR_W'(1);
                state      <= BLOCK;
            end
            if (wr && state == BLOCK) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    state            <= IDLE;
                    set_input_ready  <= 1'b1;
                    ready_thread_num <= cur_thread;
                end
            end
            if (accept && !wr && !err) begin
                err      <= 1'b1;
                err_code <= (state == IDLE) ? 2'd2 : 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_core_input_dispatch.sv
// tb_core_input_dispatch: directed table-driven checks on the default configuration plus
// hand-written sequences on a 3-core, 4-context, 8-word instance.
module tb_core_input_dispatch;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic rst;
    logic        v1, rdy1, ctx1, seq1, sir1, err1;
    logic [3:0]  th1, wr1, addr1, rtn1;
    logic [1:0]  op1, bop1, code1;
    logic [31:0] d1, din1;
    logic [15:0] full1;
    logic        v2, rdy2, seq2, sir2, err2;
    logic [4:0]  th2, rtn2;
    logic [2:0]  wr2, addr2;
    logic [1:0]  op2, bop2, ctx2, code2;
    logic [31:0] d2, din2, full2;
    core_input_dispatch dut (
        .CLK(CLK), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .in_thread_num(th1), .in_blk_op(op1), .thread_full(full1),
        .core_wr_en(wr1), .core_wr_addr(addr1), .core_din(din1), .core_ctx_num(ctx1),
        .core_seq_num(seq1), .core_blk_op(bop1), .set_input_ready(sir1),
        .ready_thread_num(rtn1), .err(err1), .err_code(code1)
    );
    core_input_dispatch #(.N_CORES(3), .N_CTX(4), .N_WORDS(8)) dut2 (
        .CLK(CLK), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
        .in_thread_num(th2), .in_blk_op(op2), .thread_full(full2),
        .core_wr_en(wr2), .core_wr_addr(addr2), .core_din(din2), .core_ctx_num(ctx2),
        .core_seq_num(seq2), .core_blk_op(bop2), .set_input_ready(sir2),
        .ready_thread_num(rtn2), .err(err2), .err_code(code2)
    );
    typedef struct {
        logic        rst, valid;
        logic [3:0]  th;
        logic [1:0]  op;
        logic [31:0] data;
        logic [15:0] full;
        logic        e_rdy;
        logic [3:0]  e_wr, e_addr;
        logic [31:0] e_din;
        logic        e_ctx, e_seq;
        logic [1:0]  e_op;
        logic        e_sir;
        logic [3:0]  e_rtn;
        logic        e_err;
        logic [1:0]  e_code;
    } vec_t;
    vec_t tbl[$];
    logic [3:0] g_rtn;
    logic       g_err;
    logic [1:0] g_code;
    int nvec = 0, nbad = 0, idx = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s @vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask
    function automatic void add(logic r, logic v, logic [3:0] th, logic [1:0] op, logic [31:0] d,
                                logic [15:0] f, logic e_rdy, logic [3:0] e_wr, logic [3:0] e_addr,
                                logic [1:0] e_op, logic e_sir);
        vec_t x;
        x.rst = r; x.valid = v; x.th = th; x.op = op; x.data = d; x.full = f;
        x.e_rdy = e_rdy; x.e_wr = e_wr; x.e_addr = e_addr; x.e_op = e_op; x.e_sir = e_sir;
        x.e_din = r ? 32'd0 : d;
        x.e_ctx = r ? 1'b0 : th[1];
        x.e_seq = r ? 1'b0 : th[0];
        x.e_rtn = g_rtn; x.e_err = g_err; x.e_code = g_code;
        tbl.push_back(x);
    endfunction
    // Full 16-word block; blk_op is changed after word 0 to show it is only sampled once
    function automatic void block(logic [3:0] th, logic [1:0] op0, logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) g_rtn = th;
            add(1'b0, 1'b1, th, (i == 0) ? op0 : ~op0, base + i, 16'h0, 1'b1,
                4'b0001 << th[3:2], 4'(i), op0, i == 15);
        end
    endfunction
    task automatic w2(logic [4:0] th, logic [1:0] op, logic [31:0] d, logic [2:0] e_wr,
                      logic [2:0] e_addr, logic [1:0] e_op, logic e_sir, logic [4:0] e_rtn,
                      logic [1:0] e_code);
        v2 = 1'b1; th2 = th; op2 = op; d2 = d;
        @(posedge CLK); #1;
        nvec++; idx++;
        chk("d2 wr_en", 32'(wr2), 32'(e_wr));
        if (e_wr != 0) begin
            chk("d2 addr", 32'(addr2), 32'(e_addr));
            chk("d2 din", din2, d);
            chk("d2 ctx", 32'(ctx2), 32'(th[2:1]));
            chk("d2 seq", 32'(seq2), 32'(th[0]));
            chk("d2 blk_op", 32'(bop2), 32'(e_op));
        end
        chk("d2 set_input_ready", 32'(sir2), 32'(e_sir));
        chk("d2 ready_thread", 32'(rtn2), 32'(e_rtn));
        chk("d2 err", 32'(err2), 32'(e_code != 0));
        chk("d2 err_code", 32'(code2), 32'(e_code));
    endtask
    initial begin
        rst = 1'b1; v1 = 1'b0; th1 = '0; op1 = '0; d1 = '0; full1 = '0;
        v2 = 1'b0; th2 = '0; op2 = '0; d2 = '0; full2 = '0;
        g_rtn = '0; g_err = 1'b0; g_code = 2'd0;
        add(1'b1, 1'b0, 4'h0, 2'd0, 32'h0, 16'h0, 1'b1, 4'b0, 4'd0, 2'd0, 1'b0);
        add(1'b1, 1'b1, 4'hB, 2'd2, 32'hdead, 16'h0, 1'b1, 4'b0, 4'd0, 2'd0, 1'b0);
        block(4'hB, 2'd2, 32'h100);
        add(1'b0, 1'b0, 4'hB, 2'd0, 32'h0, 16'h0, 1'b1, 4'b0, 4'd0, 2'd0, 1'b0);
        block(4'h0, 2'd1, 32'h200);
        block(4'hD, 2'd3, 32'h300);
        for (int k = 0; k < 3; k++)
            add(1'b0, 1'b1, 4'h5, 2'd1, 32'h400, 16'h0020, 1'b0, 4'b0, 4'd0, 2'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 8)
                add(1'b0, 1'b0, 4'h5, 2'd0, 32'h0, 16'h0020, 1'b1, 4'b0, 4'd0, 2'd0, 1'b0);
            if (i == 15) g_rtn = 4'h5;
            add(1'b0, 1'b1, 4'h5, (i == 0) ? 2'd1 : 2'd2, 32'h400 + i, (i == 0) ? 16'h0 : 16'h0020,
                1'b1, 4'b0010, 4'(i), 2'd1, i == 15);
        end
        for (int i = 0; i < 4; i++)
            add(1'b0, 1'b1, 4'h2, 2'd3, 32'h500 + i, 16'h0, 1'b1, 4'b0001, 4'(i), 2'd3, 1'b0);
        g_err = 1'b1; g_code = 2'd1;
        add(1'b0, 1'b1, 4'h3, 2'd3, 32'hbad, 16'h0, 1'b1, 4'b0, 4'd0, 2'd0, 1'b0);
        for (int i = 4; i < 16; i++) begin
            if (i == 15) g_rtn = 4'h2;
            add(1'b0, 1'b1, 4'h2, 2'd0, 32'h500 + i, 16'h0, 1'b1, 4'b0001, 4'(i), 2'd3, i == 15);
        end
        for (int i = 0; i < 7; i++)
            add(1'b0, 1'b1, 4'h7, 2'd0, 32'h600 + i, 16'h0, 1'b1, 4'b0010, 4'(i), 2'd0, 1'b0);
        g_rtn = '0; g_err = 1'b0; g_code = 2'd0;
        add(1'b1, 1'b1, 4'h7, 2'd0, 32'h607, 16'h0, 1'b1, 4'b0, 4'd0, 2'd0, 1'b0);
        block(4'h7, 2'd2, 32'h700);
        @(posedge CLK); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t x;
            x = tbl[i];
            idx = i;
            rst = x.rst; v1 = x.valid; th1 = x.th; op1 = x.op; d1 = x.data; full1 = x.full;
            #2;
            if (!x.rst) chk("in_ready", 32'(rdy1), 32'(x.e_rdy));
            @(posedge CLK); #1;
            nvec++;
            chk("wr_en", 32'(wr1), 32'(x.e_wr));
            if (x.e_wr != 0 || x.rst) begin
                chk("addr", 32'(addr1), 32'(x.e_addr));
                chk("din", din1, x.e_din);
                chk("ctx", 32'(ctx1), 32'(x.e_ctx));
                chk("seq", 32'(seq1), 32'(x.e_seq));
                chk("blk_op", 32'(bop1), 32'(x.e_op));
            end
            chk("set_input_ready", 32'(sir1), 32'(x.e_sir));
            chk("ready_thread", 32'(rtn1), 32'(x.e_rtn));
            chk("err", 32'(err1), 32'(x.e_err));
            chk("err_code", 32'(code1), 32'(x.e_code));
        end
        rst = 1'b0; v1 = 1'b0;
        w2(5'b11101, 2'd1, 32'hE0, 3'b000, 3'd0, 2'd0, 1'b0, 5'b0, 2'd2);
        for (int i = 0; i < 8; i++)
            w2(5'b10110, (i == 0) ? 2'd2 : 2'd1, 32'h800 + i, 3'b100, 3'(i), 2'd2, i == 7,
               (i == 7) ? 5'b10110 : 5'b0, 2'd2);
        for (int i = 0; i < 3; i++)
            w2(5'b00010, 2'd3, 32'h900 + i, 3'b001, 3'(i), 2'd3, 1'b0, 5'b10110, 2'd2);
        w2(5'b00011, 2'd3, 32'hbad, 3'b000, 3'd0, 2'd0, 1'b0, 5'b10110, 2'd2);
        for (int i = 3; i < 8; i++)
            w2(5'b00010, 2'd0, 32'h900 + i, 3'b001, 3'(i), 2'd3, i == 7,
               (i == 7) ? 5'b00010 : 5'b10110, 2'd2);
        v2 = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
